// File: rtl/branch_resolve_predict_pkg.sv
// branch_resolve_predict_pkg
// Shared types for the execute-stage branch resolver and its predictor:
//   - status_register          NZCV flag bundle
//   - instruction / instr_class_t  decoded execute-stage instruction
//   - take_branch_ctrl_sig, flush_pipeline_sig  redirect control types
//   - branch_link_status       tracks the first half of a two-word BL
//   - bht_counter_t + BHT_*    2-bit saturating predictor counter
//   - cond_code_t, cond_passed()  condition-code evaluation
package branch_resolve_predict_pkg;

  localparam logic [3:0] PC_REG_NUM = 4'd15;

  typedef logic [1:0] bht_counter_t;
  localparam bht_counter_t BHT_STRONG_NT = 2'b00;
  localparam bht_counter_t BHT_WEAK_NT   = 2'b01;
  localparam bht_counter_t BHT_WEAK_T    = 2'b10;
  localparam bht_counter_t BHT_STRONG_T  = 2'b11;

  // Code 4'hF is deliberately left out: it evaluates to not-taken.
  typedef enum logic [3:0] {
    COND_EQ = 4'd0,  COND_NE = 4'd1,  COND_CS = 4'd2,  COND_CC = 4'd3,
    COND_MI = 4'd4,  COND_PL = 4'd5,  COND_VS = 4'd6,  COND_VC = 4'd7,
    COND_HI = 4'd8,  COND_LS = 4'd9,  COND_GE = 4'd10, COND_LT = 4'd11,
    COND_GT = 4'd12, COND_LE = 4'd13, COND_AL = 4'd14
  } cond_code_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } status_register;

  typedef enum logic [3:0] {
    OP_OTHER         = 4'd0,
    COND_BRANCH      = 4'd1,
    UNCOND_BRANCH    = 4'd2,
    ADD_REG_SPECIAL  = 4'd3,
    MOVE_REG_SPECIAL = 4'd4,
    BRANCH_EXCH      = 4'd5,
    BRANCH_LINK_EXCH = 4'd6,
    TWO_WORD_INST_1  = 4'd7,
    TWO_WORD_INST_2  = 4'd8,
    TWO_WORD_INST_3  = 4'd9
  } instr_class_t;

  // The raw 16-bit encoding sits in the low bits, so instruction[11:8]
  // is the condition field of a conditional branch.
  typedef struct packed {
    instr_class_t op;
    logic [15:0]  bits;
  } instruction;

  typedef enum logic {NO_BRANCH = 1'b0, TAKE_BRANCH = 1'b1} take_branch_ctrl_sig;
  typedef enum logic {NO_FLUSH = 1'b0, FLUSH_PIPELINE = 1'b1} flush_pipeline_sig;
  typedef enum logic {BL_IDLE = 1'b0, BL_PENDING = 1'b1} branch_link_status;

  function automatic logic cond_passed(input logic [3:0] cond, input status_register sr);
    logic res;
    res = 1'b0;
    case (cond)
      COND_EQ: res = sr.z;
      COND_NE: res = !sr.z;
      COND_CS: res = sr.c;
      COND_CC: res = !sr.c;
      COND_MI: res = sr.n;
      COND_PL: res = !sr.n;
      COND_VS: res = sr.v;
      COND_VC: res = !sr.v;
      COND_HI: res = sr.c && !sr.z;
      COND_LS: res = !sr.c || sr.z;
      COND_GE: res = (sr.n == sr.v);
      COND_LT: res = (sr.n != sr.v);
      COND_GT: res = !sr.z && (sr.n == sr.v);
      COND_LE: res = sr.z || (sr.n != sr.v);
      COND_AL: res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/branch_resolve_predict_if.sv
// branch_resolve_predict_if
// Bundles the fetch-side prediction port and the execute-stage branch bus.
//   master: pipeline side, drives the *_i signals, receives the *_o signals
//   slave : branch_resolve_predict
interface branch_resolve_predict_if
  import branch_resolve_predict_pkg::*;
#(
  parameter int WORD_W     = 32,
  parameter int PERF_CNT_W = 16
);
  logic [WORD_W-1:0]     fetch_pc_i;
  logic                  predict_taken_o;
  logic                  is_valid_i;
  status_register        status_reg_i;
  instruction            instruction_i;
  logic [WORD_W-1:0]     program_counter_i;
  logic [WORD_W-1:0]     fallthrough_pc_i;
  logic                  predicted_taken_i;
  logic [WORD_W-1:0]     reg_data_1_i;
  logic [WORD_W-1:0]     immediate_i;
  take_branch_ctrl_sig   take_branch_o;
  flush_pipeline_sig     flush_pipeline_o;
  logic [WORD_W-1:0]     program_counter_o;
  logic [PERF_CNT_W-1:0] mispredict_cnt_o;

  modport master (
    output fetch_pc_i, is_valid_i, status_reg_i, instruction_i, program_counter_i,
           fallthrough_pc_i, predicted_taken_i, reg_data_1_i, immediate_i,
    input  predict_taken_o, take_branch_o, flush_pipeline_o, program_counter_o,
           mispredict_cnt_o
  );

  modport slave (
    input  fetch_pc_i, is_valid_i, status_reg_i, instruction_i, program_counter_i,
           fallthrough_pc_i, predicted_taken_i, reg_data_1_i, immediate_i,
    output predict_taken_o, take_branch_o, flush_pipeline_o, program_counter_o,
           mispredict_cnt_o
  );
endinterface

// File: rtl/branch_resolve_predict_bht_counter_table.sv
// bht_counter_table
// Direct-mapped table of 2-bit saturating counters.
//   clk_i, reset_i : clock, synchronous active-low reset (all entries -> BHT_INIT)
//   rd_idx_i/rd_data_o : combinational read port (pre-update value on collision)
//   wr_en_i, wr_idx_i, wr_taken_i : saturating up (taken) / down (not taken)
module bht_counter_table
  import branch_resolve_predict_pkg::*;
#(
  parameter int           BHT_DEPTH = 16,
  parameter int           BHT_IDX_W = $clog2(BHT_DEPTH),
  parameter bht_counter_t BHT_INIT  = BHT_WEAK_NT
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [BHT_IDX_W-1:0] rd_idx_i,
  output bht_counter_t         rd_data_o,
  input  logic                 wr_en_i,
  input  logic [BHT_IDX_W-1:0] wr_idx_i,
  input  logic                 wr_taken_i
);

  bht_counter_t cnt_q [BHT_DEPTH];
  bht_counter_t upd_next;
  bht_counter_t upd_cur;

  // One shared saturating adder; only the addressed entry latches it.
  assign upd_cur = cnt_q[wr_idx_i];

  always_comb begin
    upd_next = upd_cur;
    if (wr_taken_i) begin
      if (upd_cur != BHT_STRONG_T) upd_next = upd_cur + 2'd1;
    end else begin
      if (upd_cur != BHT_STRONG_NT) upd_next = upd_cur - 2'd1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < BHT_DEPTH; gi++) begin : g_ctr
      bht_counter_t cnt_reg;
      always_ff @(posedge clk_i) begin
        if (!reset_i) begin
          cnt_reg <= BHT_INIT;
        end else if (wr_en_i && (wr_idx_i == BHT_IDX_W'(gi))) begin
          cnt_reg <= upd_next;
        end
      end
      assign cnt_q[gi] = cnt_reg;
    end
  endgenerate

  assign rd_data_o = cnt_q[rd_idx_i];

endmodule

// File: rtl/branch_resolve_predict.sv
// branch_resolve_predict
// Execute-stage branch resolver with a 2-bit-counter direction predictor.
//   clk_i   : clock
//   reset_i : synchronous active-low reset
//   bus     : slave side of branch_resolve_predict_if
//     fetch_pc_i -> predict_taken_o        (fetch-time prediction)
//     execute-stage inputs -> take_branch_o / flush_pipeline_o /
//     program_counter_o (combinational redirect), mispredict_cnt_o (registered)
// Conditional branches redirect only when the carried prediction was wrong.
module branch_resolve_predict
  import branch_resolve_predict_pkg::*;
#(
  parameter int           WORD_W     = 32,
  parameter int           BHT_DEPTH  = 16,
  parameter int           BHT_IDX_W  = $clog2(BHT_DEPTH),
  parameter bht_counter_t BHT_INIT   = BHT_WEAK_NT,
  parameter int           PERF_CNT_W = 16
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  branch_resolve_predict_if.slave bus
);

  logic              cond_taken;
  logic              dest_is_pc;
  logic              is_cond;
  logic              is_two_word;
  logic              cond_mispredict;
  logic              redirect;
  logic              redirect_gated;
  logic [WORD_W-1:0] target;
  logic              train_en;
  bht_counter_t      pred_ctr;

  branch_link_status         bl_pending_reg, bl_pending_next;
  logic [PERF_CNT_W-1:0]     mispredict_cnt_reg;

  assign cond_taken  = cond_passed(bus.instruction_i.bits[11:8], bus.status_reg_i);
  assign dest_is_pc  = ({bus.instruction_i.bits[7], bus.instruction_i.bits[2:0]} == PC_REG_NUM);
  assign is_cond     = (bus.instruction_i.op == COND_BRANCH);
  assign is_two_word = (bus.instruction_i.op inside {TWO_WORD_INST_1, TWO_WORD_INST_2,
                                                     TWO_WORD_INST_3});
  assign cond_mispredict = is_cond && (cond_taken != bus.predicted_taken_i);

  // Ungated redirect decision; validity and reset are applied afterwards.
  always_comb begin
    redirect = 1'b0;
    target   = '0;
    case (bus.instruction_i.op)
      COND_BRANCH: begin
        if (cond_mispredict) begin
          redirect = 1'b1;
          target   = cond_taken ? (bus.program_counter_i + bus.immediate_i)
                                : bus.fallthrough_pc_i;
        end
      end
      UNCOND_BRANCH: begin
        redirect = 1'b1;
        target   = bus.program_counter_i + bus.immediate_i;
      end
      ADD_REG_SPECIAL: begin
        redirect = dest_is_pc;
        target   = bus.program_counter_i + bus.reg_data_1_i;
      end
      MOVE_REG_SPECIAL: begin
        redirect = dest_is_pc;
        target   = bus.reg_data_1_i;
      end
      BRANCH_EXCH, BRANCH_LINK_EXCH: begin
        redirect = 1'b1;
        target   = bus.reg_data_1_i;
      end
      TWO_WORD_INST_1, TWO_WORD_INST_2, TWO_WORD_INST_3: begin
        redirect = (bl_pending_reg == BL_PENDING);
        target   = bus.program_counter_i + bus.immediate_i;
      end
      default: begin
        redirect = 1'b0;
        target   = '0;
      end
    endcase
  end

  assign redirect_gated       = redirect && bus.is_valid_i && reset_i;
  assign bus.take_branch_o    = redirect_gated ? TAKE_BRANCH : NO_BRANCH;
  assign bus.flush_pipeline_o = redirect_gated ? FLUSH_PIPELINE : NO_FLUSH;
  assign bus.program_counter_o = redirect_gated ? target : '0;

  // A valid two-word half arms the pair only when nothing is pending; the
  // completing half redirects, so every other valid instruction disarms it.
  always_comb begin
    bl_pending_next = bl_pending_reg;
    if (bus.is_valid_i) begin
      if (is_two_word && (bl_pending_reg == BL_IDLE)) bl_pending_next = BL_PENDING;
      else                                             bl_pending_next = BL_IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      bl_pending_reg     <= BL_IDLE;
      mispredict_cnt_reg <= '0;
    end else begin
      bl_pending_reg <= bl_pending_next;
      if (bus.is_valid_i && cond_mispredict && (mispredict_cnt_reg != '1)) begin
        mispredict_cnt_reg <= mispredict_cnt_reg + 1'b1;
      end
    end
  end

  assign bus.mispredict_cnt_o = mispredict_cnt_reg;

  assign train_en = bus.is_valid_i && is_cond;

  bht_counter_table #(
    .BHT_DEPTH (BHT_DEPTH),
    .BHT_IDX_W (BHT_IDX_W),
    .BHT_INIT  (BHT_INIT)
  ) u_bht (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .rd_idx_i   (bus.fetch_pc_i[BHT_IDX_W:1]),
    .rd_data_o  (pred_ctr),
    .wr_en_i    (train_en),
    .wr_idx_i   (bus.program_counter_i[BHT_IDX_W:1]),
    .wr_taken_i (cond_taken)
  );

  assign bus.predict_taken_o = pred_ctr[1];

  // Encoding bits not needed for branch resolution, and fetch PC bits
  // outside the table index.
  logic unused_bits;
  assign unused_bits = ^{bus.instruction_i.bits[15:12], bus.instruction_i.bits[6:3],
                         bus.fetch_pc_i[WORD_W-1:BHT_IDX_W+1], bus.fetch_pc_i[0], pred_ctr[0]};

endmodule

// File: tb/tb_branch_resolve_predict.sv
// tb_branch_resolve_predict
// Directed scenarios followed by random traffic, checked against a
// behavioural model (integer counter array, pending-BL flag, miss count).
module tb_branch_resolve_predict;
  import branch_resolve_predict_pkg::*;

  localparam int WW    = 32;
  localparam int DEPTH = 16;
  localparam int PCW   = 4;
  localparam int MAXC  = (1 << PCW) - 1;

  logic clk_i   = 1'b0;
  logic reset_i = 1'b0;
  always #5 clk_i = ~clk_i;

  branch_resolve_predict_if #(.WORD_W(WW), .PERF_CNT_W(PCW)) bus ();

  branch_resolve_predict #(
    .WORD_W     (WW),
    .BHT_DEPTH  (DEPTH),
    .BHT_INIT   (BHT_WEAK_NT),
    .PERF_CNT_W (PCW)
  ) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (bus)
  );

  // Reference model state
  int ctr [DEPTH];
  int mcnt;
  bit blp;
  int tests;
  int fails;

  // Last observed combinational outputs
  logic        obs_take;
  logic        obs_flush;
  logic [31:0] obs_pc;
  logic        obs_pred;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit flags_pass(input int code, input status_register s);
    case (code)
      0:  return s.z == 1;
      1:  return s.z == 0;
      2:  return s.c == 1;
      3:  return s.c == 0;
      4:  return s.n == 1;
      5:  return s.n == 0;
      6:  return s.v == 1;
      7:  return s.v == 0;
      8:  return (s.c == 1) && (s.z == 0);
      9:  return (s.c == 0) || (s.z == 1);
      10: return s.n == s.v;
      11: return s.n != s.v;
      12: return (s.z == 0) && (s.n == s.v);
      13: return (s.z == 1) || (s.n != s.v);
      14: return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 2) % DEPTH);
  endfunction

  // Expected redirect for the current inputs and model state.
  task automatic model_redirect(output bit redir, output logic [31:0] tgt);
    instruction ins;
    int dest;
    bit act;
    ins   = bus.instruction_i;
    redir = 0;
    tgt   = 0;
    dest  = int'(ins.bits[7]) * 8 + int'(ins.bits[2:0]);
    act   = flags_pass(int'(ins.bits[11:8]), bus.status_reg_i);
    if (reset_i === 1'b1 && bus.is_valid_i === 1'b1) begin
      case (ins.op)
        COND_BRANCH: if (act != bus.predicted_taken_i) begin
          redir = 1;
          tgt   = act ? bus.program_counter_i + bus.immediate_i : bus.fallthrough_pc_i;
        end
        UNCOND_BRANCH: begin redir = 1; tgt = bus.program_counter_i + bus.immediate_i; end
        ADD_REG_SPECIAL: if (dest == 15) begin
          redir = 1; tgt = bus.program_counter_i + bus.reg_data_1_i;
        end
        MOVE_REG_SPECIAL: if (dest == 15) begin redir = 1; tgt = bus.reg_data_1_i; end
        BRANCH_EXCH, BRANCH_LINK_EXCH: begin redir = 1; tgt = bus.reg_data_1_i; end
        TWO_WORD_INST_1, TWO_WORD_INST_2, TWO_WORD_INST_3: if (blp) begin
          redir = 1; tgt = bus.program_counter_i + bus.immediate_i;
        end
        default: ;
      endcase
    end
  endtask

  // Model state update at a rising edge.
  task automatic model_clock();
    instruction ins;
    bit act;
    int i;
    ins = bus.instruction_i;
    act = flags_pass(int'(ins.bits[11:8]), bus.status_reg_i);
    if (reset_i === 1'b0) begin
      for (int k = 0; k < DEPTH; k++) ctr[k] = 1;
      blp  = 0;
      mcnt = 0;
    end else if (bus.is_valid_i === 1'b1) begin
      if (ins.op == COND_BRANCH) begin
        i = idx_of(bus.program_counter_i);
        ctr[i] = act ? ((ctr[i] < 3) ? ctr[i] + 1 : 3) : ((ctr[i] > 0) ? ctr[i] - 1 : 0);
        if (act != bus.predicted_taken_i && mcnt < MAXC) mcnt = mcnt + 1;
      end
      if (ins.op inside {TWO_WORD_INST_1, TWO_WORD_INST_2, TWO_WORD_INST_3}) blp = !blp;
      else blp = 0;
    end
  endtask

  // Called just after a falling edge with inputs already applied.
  task automatic step(input string tag);
    bit          er;
    logic [31:0] et;
    logic        ep;
    #1;
    model_redirect(er, et);
    ep        = (ctr[idx_of(bus.fetch_pc_i)] >= 2);
    obs_take  = bus.take_branch_o;
    obs_flush = bus.flush_pipeline_o;
    obs_pc    = bus.program_counter_o;
    obs_pred  = bus.predict_taken_o;
    chk({tag, ".take"}, 64'(obs_take), 64'(er));
    chk({tag, ".flush"}, 64'(obs_flush), 64'(er));
    chk({tag, ".pc"}, 64'(obs_pc), 64'(et));
    chk({tag, ".pred"}, 64'(obs_pred), 64'(ep));
    @(posedge clk_i);
    model_clock();
    @(negedge clk_i);
    chk({tag, ".mcnt"}, 64'(bus.mispredict_cnt_o), 64'(mcnt));
    $display("[TB] %s op=%0d valid=%0b pc=0x%0h take=%0b tgt=0x%0h pred=%0b mcnt=%0d",
             tag, bus.instruction_i.op, bus.is_valid_i, bus.program_counter_i,
             obs_take, obs_pc, obs_pred, bus.mispredict_cnt_o);
  endtask

  task automatic drive(input bit v, input instr_class_t op, input logic [15:0] bits,
                       input logic [31:0] pc, input logic [31:0] imm, input bit pred);
    bus.is_valid_i        = v;
    bus.instruction_i.op  = op;
    bus.instruction_i.bits = bits;
    bus.program_counter_i = pc;
    bus.immediate_i       = imm;
    bus.predicted_taken_i = pred;
    bus.fallthrough_pc_i  = pc + 32'd2;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    bus.fetch_pc_i    = '0;
    bus.status_reg_i  = '0;
    bus.reg_data_1_i  = '0;
    drive(0, OP_OTHER, 16'h0, 32'h0, 32'h0, 0);
    reset_i = 1'b0;
    repeat (2) @(posedge clk_i);
    model_clock();
    @(negedge clk_i);

    // Redirect outputs forced low while in reset.
    drive(1, UNCOND_BRANCH, 16'h0, 32'h40, 32'h8, 0);
    step("rst");
    chk("rst_take", 64'(obs_take), 64'd0);
    reset_i = 1'b1;

    // 1: EQ, Z=1, predicted not-taken -> redirect to 0x120.
    bus.status_reg_i = '{n: 1'b0, z: 1'b1, c: 1'b0, v: 1'b0};
    bus.fetch_pc_i   = 32'h100;
    drive(1, COND_BRANCH, 16'h0000, 32'h100, 32'h20, 0);
    step("t1");
    chk("t1_pc", 64'(obs_pc), 64'h120);
    chk("t1_mcnt", 64'(bus.mispredict_cnt_o), 64'd1);

    // 2: same branch three more times with the current prediction.
    for (int r = 0; r < 3; r++) begin
      drive(1, COND_BRANCH, 16'h0000, 32'h100, 32'h20, ctr[0] >= 2);
      step("t2");
      chk("t2_take", 64'(obs_take), 64'd0);
    end
    chk("t2_mcnt", 64'(bus.mispredict_cnt_o), 64'd1);

    // 3: NE with Z=1 predicted taken -> back to fallthrough 0x102.
    drive(1, COND_BRANCH, 16'h0100, 32'h100, 32'h20, 1);
    step("t3");
    chk("t3_pc", 64'(obs_pc), 64'h102);

    // 4: two-word BL split by a bubble.
    drive(1, TWO_WORD_INST_1, 16'h0, 32'h1FE, 32'h0, 0);
    step("t4a");
    drive(0, OP_OTHER, 16'h0, 32'h0, 32'h0, 0);
    step("t4b");
    drive(1, TWO_WORD_INST_2, 16'h0, 32'h200, 32'h400, 0);
    step("t4c");
    chk("t4_pc", 64'(obs_pc), 64'h600);
    drive(1, TWO_WORD_INST_3, 16'h0, 32'h300, 32'h10, 0);
    step("t4d");
    chk("t4_cleared", 64'(obs_take), 64'd0);
    drive(1, OP_OTHER, 16'h0, 32'h0, 32'h0, 0);
    step("t4e");

    // 5: MOV pc, Rm gated by valid.
    bus.reg_data_1_i = 32'h3000;
    drive(0, MOVE_REG_SPECIAL, 16'h0087, 32'h50, 32'h0, 0);
    step("t5a");
    chk("t5_invalid", 64'(obs_take), 64'd0);
    drive(1, MOVE_REG_SPECIAL, 16'h0087, 32'h50, 32'h0, 0);
    step("t5b");
    chk("t5_pc", 64'(obs_pc), 64'h3000);

    // 6: read-during-write on index 5, then reset mid-stream.
    bus.fetch_pc_i = 32'h0A;
    drive(1, COND_BRANCH, 16'h0E00, 32'h0A, 32'h4, 0);
    step("t6a");
    chk("t6_pred_same", 64'(obs_pred), 64'd0);
    drive(0, OP_OTHER, 16'h0, 32'h0, 32'h0, 0);
    step("t6b");
    chk("t6_pred_next", 64'(obs_pred), 64'd1);
    drive(1, TWO_WORD_INST_1, 16'h0, 32'h20, 32'h0, 0);
    step("t6c");
    reset_i = 1'b0;
    drive(1, UNCOND_BRANCH, 16'h0, 32'h80, 32'h8, 0);
    step("t6d");
    chk("t6_rst_pc", 64'(obs_pc), 64'd0);
    reset_i = 1'b1;
    drive(1, TWO_WORD_INST_2, 16'h0, 32'h20, 32'h8, 0);
    step("t6e");
    chk("t6_bl_cleared", 64'(obs_take), 64'd0);
    chk("t6_pred_reset", 64'(obs_pred), 64'd0);
    chk("t6_mcnt_reset", 64'(bus.mispredict_cnt_o), 64'd0);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      logic [15:0] b;
      logic [31:0] pc;
      b  = 16'($urandom);
      if ($urandom_range(0, 1) == 1) begin b[7] = 1'b1; b[2:0] = 3'd7; end
      pc = 32'($urandom_range(0, 511)) * 32'd2;
      reset_i          = ($urandom_range(0, 59) != 0);
      bus.status_reg_i = 4'($urandom);
      bus.reg_data_1_i = $urandom;
      bus.fetch_pc_i   = ($urandom_range(0, 1) == 1) ? pc : 32'($urandom_range(0, 1023));
      drive($urandom_range(0, 3) != 0, instr_class_t'($urandom_range(0, 9)), b, pc, $urandom,
            ($urandom_range(0, 2) == 0) ? bit'($urandom_range(0, 1)) : (ctr[idx_of(pc)] >= 2));
      step("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
